// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: sequencing FSM for the CORDIC sine/cosine datapath.
// Runs one computation per request: load operands, N_ITER micro-rotations,
// capture result, then hold a ready/ack handshake with the consumer.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   start     in   request a computation (sampled only in IDLE)
//   ack       in   consumer took the result (sampled only in DONE)
//   busy      out  high in every state except IDLE
//   ready     out  result registers valid (DONE only)
//   load_en   out  enable for operand input registers
//   iter_en   out  enable for x/y/z iteration registers
//   mux_sel   out  0 = datapath takes loaded operands, 1 = fed-back values
//   iter_idx  out  current iteration: shift amount / atan LUT address
//   out_en    out  enable for sin/cos result registers
module cordic_iter_ctrl #(
    parameter int unsigned N_ITER = 24,
    parameter int unsigned ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ack,
    output logic              busy,
    output logic              ready,
    output logic              load_en,
    output logic              iter_en,
    output logic              mux_sel,
    output logic [ITER_W-1:0] iter_idx,
    output logic              out_en
);

    localparam logic [ITER_W-1:0] LAST = ITER_W'(N_ITER - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;

    logic              busy_d, ready_d, load_en_d, iter_en_d, mux_sel_d, out_en_d;
    logic [ITER_W-1:0] iter_idx_d;

    // State, counter and output registers. Outputs are decoded from the
    // next state/counter so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            load_en  <= 1'b0;
            iter_en  <= 1'b0;
            mux_sel  <= 1'b0;
            iter_idx <= '0;
            out_en   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy     <= busy_d;
            ready    <= ready_d;
            load_en  <= load_en_d;
            iter_en  <= iter_en_d;
            mux_sel  <= mux_sel_d;
            iter_idx <= iter_idx_d;
            out_en   <= out_en_d;
        end
    end

    // Next-state, counter and Moore output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = STORE;
                end else begin
                    cnt_d = cnt_q + ITER_W'(1);
                end
            end
            STORE: begin
                state_d = DONE;
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d     = (state_d != IDLE);
        ready_d    = (state_d == DONE);
        load_en_d  = (state_d == LOAD);
        iter_en_d  = (state_d == ITER);
        out_en_d   = (state_d == STORE);
        // First rotation consumes the freshly loaded operands.
        mux_sel_d  = (state_d == ITER) && (cnt_d != '0);
        iter_idx_d = (state_d == ITER) ? cnt_d : '0;
    end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl: the stimulus pushes the expected
// output bundle for each clock edge; a monitor pops and compares after the edge.
module tb_cordic_iter_ctrl;

    typedef struct packed {
        logic       busy;
        logic       ready;
        logic       load_en;
        logic       iter_en;
        logic       mux_sel;
        logic       out_en;
        logic [4:0] idx;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Nominal instance, N_ITER=24
    logic       rst24, start24, ack24;
    logic       busy24, ready24, load24, iter24, mux24, out24;
    logic [4:0] idx24;

    // Boundary instance, N_ITER=2, ITER_W=1
    logic       rst2, start2, ack2;
    logic       busy2, ready2, load2, iter2, mux2, out2;
    logic [0:0] idx2;

    cordic_iter_ctrl #(.N_ITER(24), .ITER_W(5)) dut24 (
        .clk(clk), .rst(rst24), .start(start24), .ack(ack24),
        .busy(busy24), .ready(ready24), .load_en(load24), .iter_en(iter24),
        .mux_sel(mux24), .iter_idx(idx24), .out_en(out24)
    );

    cordic_iter_ctrl #(.N_ITER(2), .ITER_W(1)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .ack(ack2),
        .busy(busy2), .ready(ready2), .load_en(load2), .iter_en(iter2),
        .mux_sel(mux2), .iter_idx(idx2), .out_en(out2)
    );

    vec_t q24[$];
    vec_t q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t pack24();
        return '{busy24, ready24, load24, iter24, mux24, out24, idx24};
    endfunction

    function automatic vec_t pack2();
        return '{busy2, ready2, load2, iter2, mux2, out2, 5'(idx2)};
    endfunction

    // Hand-written expected bundles for each phase of a computation
    function automatic vec_t exp_idle();
        return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    endfunction
    function automatic vec_t exp_load();
        return '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    endfunction
    function automatic vec_t exp_iter(input int i);
        return '{1'b1, 1'b0, 1'b0, 1'b1, (i != 0), 1'b0, 5'(i)};
    endfunction
    function automatic vec_t exp_store();
        return '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    endfunction
    function automatic vec_t exp_done();
        return '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got busy/rdy/ld/it/mux/out/idx=%b expected %b",
                     name, $time, got, exp);
        end
    endtask

    // Drive inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input int d, input logic r, input logic st, input logic ak,
                        input vec_t e);
        @(negedge clk);
        if (d == 0) begin
            rst24 = r; start24 = st; ack24 = ak;
            q24.push_back(e);
        end else begin
            rst2 = r; start2 = st; ack2 = ak;
            q2.push_back(e);
        end
    endtask

    // One full computation from IDLE up to DONE. 'hold' keeps start high the
    // whole way; 'noise' adds stray start/ack pulses that must be ignored.
    task automatic comp(input int d, input int n, input logic hold, input logic noise);
        step(d, 1'b0, 1'b1, 1'b0, exp_load());
        for (int i = 0; i < n; i++) begin
            step(d, 1'b0, hold | (noise & (i == 5)), noise & (i == 8), exp_iter(i));
        end
        step(d, 1'b0, hold | noise, 1'b0, exp_store());
        step(d, 1'b0, hold | noise, 1'b0, exp_done());
    endtask

    // Monitor: compare each queued expectation just after its clock edge.
    initial begin
        vec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q24.size() > 0) begin
                e = q24.pop_front();
                check("dut24", pack24(), e);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("dut2", pack2(), e);
            end
        end
    end

    initial begin
        rst24 = 1'b1; start24 = 1'b0; ack24 = 1'b0;
        rst2  = 1'b1; start2  = 1'b0; ack2  = 1'b0;

        // Reset state and release
        step(0, 1'b1, 1'b0, 1'b0, exp_idle());
        step(0, 1'b0, 1'b0, 1'b0, exp_idle());
        step(1, 1'b0, 1'b0, 1'b0, exp_idle());

        // Nominal computation; ready rises 26 edges after start is taken
        comp(0, 24, 1'b0, 1'b0);

        // Hold ack low for 50 cycles in DONE, then acknowledge
        for (int i = 0; i < 50; i++) step(0, 1'b0, 1'b0, 1'b0, exp_done());
        step(0, 1'b0, 1'b0, 1'b1, exp_idle());
        step(0, 1'b0, 1'b0, 1'b0, exp_idle());

        // Stray start/ack during ITER and STORE do not disturb timing
        comp(0, 24, 1'b0, 1'b1);
        step(0, 1'b0, 1'b0, 1'b0, exp_done());
        step(0, 1'b0, 1'b0, 1'b1, exp_idle());
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0, exp_idle());

        // start and ack together in DONE: back to IDLE, start not captured;
        // start held high then launches the next LOAD one cycle later
        comp(0, 24, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, exp_idle());
        comp(0, 24, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, exp_idle());
        step(0, 1'b0, 1'b1, 1'b0, exp_load());
        step(0, 1'b0, 1'b0, 1'b0, exp_iter(0));
        for (int i = 1; i <= 10; i++) step(0, 1'b0, 1'b0, 1'b0, exp_iter(i));

        // Asynchronous reset mid-ITER at idx 10: outputs clear without a clock edge
        @(negedge clk);
        rst24 = 1'b1;
        #1;
        check("async_rst", pack24(), exp_idle());
        step(0, 1'b1, 1'b0, 1'b0, exp_idle());
        step(0, 1'b0, 1'b0, 1'b0, exp_idle());
        step(0, 1'b0, 1'b0, 1'b0, exp_idle());

        // Boundary instance: two iterations, ready after edge k+4
        comp(1, 2, 1'b0, 1'b0);
        step(1, 1'b0, 1'b0, 1'b0, exp_done());
        step(1, 1'b0, 1'b0, 1'b1, exp_idle());
        step(1, 1'b0, 1'b0, 1'b0, exp_idle());

        @(posedge clk);
        #2;
        n_checks++;
        if (q24.size() == 0 && q2.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d/%0d queued entries expected 0/0", q24.size(), q2.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
